// File: rtl/delay_line_var.sv
`default_nettype none
// ============================================================================
// delay_line_var : multi-lane register delay line, run-time tap 1..MAX_LATENCY
// Option macro DELAY_LINE_VAR_DATA_RESET_EN : data stages also cleared by arst_i
// Revision: 1.0
// ============================================================================
module delay_line_var #(
  parameter int WIDTH           = 32,
  parameter int CHANNELS        = 2,
  parameter int MAX_LATENCY     = 8,
  parameter int DEFAULT_LATENCY = 4,
  parameter int LAT_W           = 8
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      ena_i,
  input  logic [LAT_W-1:0]          lat_sel_i,
  input  logic [WIDTH*CHANNELS-1:0] din_i,
  input  logic                      din_valid_i,
  output logic [WIDTH*CHANNELS-1:0] dout_o,
  output logic                      dout_valid_o,
  output logic [LAT_W-1:0]          lat_cur_o,
  output logic                      settled_o,
  output logic                      lat_err_o
);

  localparam int DW = WIDTH * CHANNELS;

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e                 state_q;
  logic [LAT_W-1:0]       fill_cnt_q;
  logic [LAT_W-1:0]       lat_cur_q;
  logic                   settled_q;
  logic                   lat_err_q;
  logic [MAX_LATENCY-1:0] valid_q;
  logic [MAX_LATENCY-1:0] valid_d;

`ifdef DELAY_LINE_VAR_DATA_RESET_EN
  logic [DW-1:0]          data_q [MAX_LATENCY];
`else
  logic [DW-1:0]          data_q [MAX_LATENCY] = '{default: '0};
`endif

  logic [LAT_W-1:0]       lat_eff;
  logic                   lat_clamp;
  logic                   lat_chg;

  // Clamp first so an out-of-range request that lands on lat_cur is not a change.
  always_comb begin
    lat_eff   = lat_sel_i;
    lat_clamp = 1'b0;
    if (lat_sel_i == '0) begin
      lat_eff   = LAT_W'(1);
      lat_clamp = 1'b1;
    end else if (lat_sel_i > LAT_W'(MAX_LATENCY)) begin
      lat_eff   = LAT_W'(MAX_LATENCY);
      lat_clamp = 1'b1;
    end
  end

  assign lat_chg = (lat_eff != lat_cur_q);

  // A latency change kills every in-flight valid except the one entering stage 0.
  always_comb begin
    valid_d = valid_q;
    if (ena_i) begin
      valid_d = {valid_q[MAX_LATENCY-2:0], din_valid_i};
    end
    if (lat_chg) begin
      valid_d[MAX_LATENCY-1:1] = '0;
      if (!ena_i) begin
        valid_d[0] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= S_FILL;
      fill_cnt_q <= '0;
      settled_q  <= 1'b0;
      lat_cur_q  <= LAT_W'(DEFAULT_LATENCY);
      lat_err_q  <= 1'b0;
      valid_q    <= '0;
    end else begin
      lat_err_q <= lat_clamp;
      valid_q   <= valid_d;
      if (lat_chg) begin
        lat_cur_q  <= lat_eff;
        state_q    <= S_FILL;
        fill_cnt_q <= '0;
        settled_q  <= 1'b0;
      end else if (ena_i) begin
        case (state_q)
          S_FILL: begin
            if (fill_cnt_q == lat_cur_q - LAT_W'(1)) begin
              state_q   <= S_RUN;
              settled_q <= 1'b1;
            end else begin
              fill_cnt_q <= fill_cnt_q + LAT_W'(1);
            end
          end
          S_RUN: begin
            settled_q <= 1'b1;
          end
          default: begin
            state_q   <= S_FILL;
            settled_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef DELAY_LINE_VAR_DATA_RESET_EN
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < MAX_LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else if (ena_i) begin
      data_q[0] <= din_i;
      for (int i = 1; i < MAX_LATENCY; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (ena_i) begin
      data_q[0] <= din_i;
      for (int i = 1; i < MAX_LATENCY; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end
  end
`endif

  // Tap mux straight off the stage registers: lat_cur stages of latency, no output flop.
  always_comb begin
    dout_o       = data_q[0];
    dout_valid_o = valid_q[0];
    for (int i = 0; i < MAX_LATENCY; i++) begin
      if (lat_cur_q == LAT_W'(i + 1)) begin
        dout_o       = data_q[i];
        dout_valid_o = valid_q[i];
      end
    end
  end

  assign lat_cur_o = lat_cur_q;
  assign settled_o = settled_q;
  assign lat_err_o = lat_err_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_line_var.sv
`default_nettype none
// Bench for delay_line_var: words are queued with their due enabled-edge index
// at capture and popped when that edge arrives; control outputs come from a small model.
module tb_delay_line_var;
  localparam int WIDTH           = 32;
  localparam int CHANNELS        = 2;
  localparam int MAX_LATENCY     = 8;
  localparam int DEFAULT_LATENCY = 4;
  localparam int LAT_W           = 8;
  localparam int DW              = WIDTH * CHANNELS;

  logic             clk = 1'b0;
  logic             arst = 1'b1;
  logic             ena = 1'b0;
  logic [LAT_W-1:0] lat_sel = LAT_W'(4);
  logic [DW-1:0]    din = '0;
  logic             din_valid = 1'b0;
  logic [DW-1:0]    dout;
  logic             dout_valid;
  logic [LAT_W-1:0] lat_cur;
  logic             settled;
  logic             lat_err;

  delay_line_var #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_LATENCY(MAX_LATENCY),
    .DEFAULT_LATENCY(DEFAULT_LATENCY), .LAT_W(LAT_W)
  ) dut (
    .clk_i(clk), .arst_i(arst), .ena_i(ena), .lat_sel_i(lat_sel),
    .din_i(din), .din_valid_i(din_valid), .dout_o(dout),
    .dout_valid_o(dout_valid), .lat_cur_o(lat_cur), .settled_o(settled),
    .lat_err_o(lat_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    int            tgt;
  } ent_t;

  ent_t          sb[$];
  int            m_lat = DEFAULT_LATENCY;
  int            m_e = 0;
  int            m_fill = 0;
  bit            m_err = 1'b0;
  bit            m_exp_valid = 1'b0;
  logic [DW-1:0] m_exp_data = '0;
  logic [31:0]   cnt = 32'd1;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic model_reset();
    sb.delete();
    m_lat       = DEFAULT_LATENCY;
    m_e         = 0;
    m_fill      = 0;
    m_err       = 1'b0;
    m_exp_valid = 1'b0;
  endtask

  function automatic logic [LAT_W+2:0] exp_ctrl();
    return {m_exp_valid, LAT_W'(m_lat), (m_fill >= m_lat), m_err};
  endfunction

  function automatic logic [LAT_W+2:0] act_ctrl();
    return {dout_valid, lat_cur, settled, lat_err};
  endfunction

  task automatic drive(input bit e, input bit v);
    ena       = e;
    din_valid = v;
    din       = {~cnt, cnt};
    cnt       = cnt + 32'd1;
  endtask

  // Advance one clock and update the reference model from the inputs seen at that edge.
  task automatic tick();
    int eff;
    bit chg;
    @(posedge clk);
    if (arst) begin
      model_reset();
    end else begin
      if (lat_sel == '0) eff = 1;
      else if (int'(lat_sel) > MAX_LATENCY) eff = MAX_LATENCY;
      else eff = int'(lat_sel);
      m_err = (lat_sel == '0) || (int'(lat_sel) > MAX_LATENCY);
      chg   = (eff != m_lat);
      if (chg) begin
        sb.delete();
        m_lat       = eff;
        m_fill      = 0;
        m_exp_valid = 1'b0;
      end else if (ena && m_fill < 255) begin
        m_fill++;
      end
      if (ena) begin
        m_e++;
        if (din_valid) sb.push_back('{din, m_e + m_lat - 1});
        m_exp_valid = 1'b0;
        if (sb.size() > 0 && sb[0].tgt == m_e) begin
          m_exp_valid = 1'b1;
          m_exp_data  = sb[0].d;
          sb.delete(0);
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    drive(1'b0, 1'b0);
    model_reset();
    tick();
    tick();
    n_chk++;
    if (act_ctrl() !== exp_ctrl())
      $display("FAIL reset_ctrl: got %h expected %h", act_ctrl(), exp_ctrl());
    else n_pass++;
`ifdef DELAY_LINE_VAR_DATA_RESET_EN
    n_chk++;
    if (dout !== '0) $display("FAIL reset_data: got %h expected 0", dout);
    else n_pass++;
`endif
    arst = 1'b0;
  endtask

  task automatic test_basic();
    lat_sel = LAT_W'(4);
    cnt     = 32'd1;
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 1'b1);
      tick();
      n_chk++;
      if (act_ctrl() !== exp_ctrl())
        $display("FAIL basic_ctrl cyc %0d: got %h expected %h", i, act_ctrl(), exp_ctrl());
      else n_pass++;
      if (m_exp_valid) begin
        n_chk++;
        if (dout !== m_exp_data)
          $display("FAIL basic_data cyc %0d: got %h expected %h", i, dout, m_exp_data);
        else n_pass++;
      end
    end
  endtask

  task automatic test_lat_change();
    lat_sel = LAT_W'(7);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1);
      tick();
      n_chk++;
      if (act_ctrl() !== exp_ctrl())
        $display("FAIL chg_ctrl cyc %0d: got %h expected %h", i, act_ctrl(), exp_ctrl());
      else n_pass++;
      if (m_exp_valid) begin
        n_chk++;
        if (dout !== m_exp_data)
          $display("FAIL chg_data cyc %0d: got %h expected %h", i, dout, m_exp_data);
        else n_pass++;
      end
    end
  endtask

  task automatic test_ena_toggle();
    lat_sel = LAT_W'(3);
    for (int i = 0; i < 24; i++) begin
      drive((i % 2) == 0, 1'b1);
      tick();
      n_chk++;
      if (act_ctrl() !== exp_ctrl())
        $display("FAIL ena_ctrl cyc %0d: got %h expected %h", i, act_ctrl(), exp_ctrl());
      else n_pass++;
      if (m_exp_valid) begin
        n_chk++;
        if (dout !== m_exp_data)
          $display("FAIL ena_data cyc %0d: got %h expected %h", i, dout, m_exp_data);
        else n_pass++;
      end
    end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 14; i++) begin
      lat_sel = (i == 0) ? LAT_W'(0) : LAT_W'(200);
      drive(1'b1, 1'b1);
      tick();
      n_chk++;
      if (act_ctrl() !== exp_ctrl())
        $display("FAIL clamp_ctrl cyc %0d: got %h expected %h", i, act_ctrl(), exp_ctrl());
      else n_pass++;
      if (m_exp_valid) begin
        n_chk++;
        if (dout !== m_exp_data)
          $display("FAIL clamp_data cyc %0d: got %h expected %h", i, dout, m_exp_data);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    lat_sel = LAT_W'(6);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1);
      tick();
    end
    arst = 1'b1;
    model_reset();
    #1;
    n_chk++;
    if (act_ctrl() !== exp_ctrl())
      $display("FAIL midrst_ctrl: got %h expected %h", act_ctrl(), exp_ctrl());
    else n_pass++;
`ifdef DELAY_LINE_VAR_DATA_RESET_EN
    n_chk++;
    if (dout !== '0) $display("FAIL midrst_data: got %h expected 0", dout);
    else n_pass++;
`endif
    lat_sel = LAT_W'(4);
    tick();
    arst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1);
      tick();
      n_chk++;
      if (act_ctrl() !== exp_ctrl())
        $display("FAIL postrst_ctrl cyc %0d: got %h expected %h", i, act_ctrl(), exp_ctrl());
      else n_pass++;
      if (m_exp_valid) begin
        n_chk++;
        if (dout !== m_exp_data)
          $display("FAIL postrst_data cyc %0d: got %h expected %h", i, dout, m_exp_data);
        else n_pass++;
      end
    end
  endtask

  // Change latency on the very edge that would otherwise complete the fill.
  task automatic test_change_at_run();
    for (int i = 0; i < 12; i++) begin
      lat_sel = (i < 5) ? LAT_W'(5) : LAT_W'(3);
      drive(1'b1, 1'b1);
      tick();
      n_chk++;
      if (act_ctrl() !== exp_ctrl())
        $display("FAIL runchg_ctrl cyc %0d: got %h expected %h", i, act_ctrl(), exp_ctrl());
      else n_pass++;
      if (m_exp_valid) begin
        n_chk++;
        if (dout !== m_exp_data)
          $display("FAIL runchg_data cyc %0d: got %h expected %h", i, dout, m_exp_data);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) lat_sel = LAT_W'($urandom_range(0, 12));
      ena       = ($urandom_range(0, 3) != 0);
      din_valid = ($urandom_range(0, 4) != 0);
      din       = {$urandom, $urandom};
      tick();
      n_chk++;
      if (act_ctrl() !== exp_ctrl())
        $display("FAIL rand_ctrl cyc %0d: got %h expected %h", i, act_ctrl(), exp_ctrl());
      else n_pass++;
      if (m_exp_valid) begin
        n_chk++;
        if (dout !== m_exp_data)
          $display("FAIL rand_data cyc %0d: got %h expected %h", i, dout, m_exp_data);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lat_change();
    test_ena_toggle();
    test_clamp();
    test_reset_midstream();
    test_change_at_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
